// File: rtl/nos_dac_transmitter.sv
// Serializer for the NOS DAC pins: parallel L/R sample pairs shifted out MSB first
// on data_l/data_r with bck, and le marking the LSB bit period of each frame.
module nos_dac_transmitter #(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data_l,
    input  logic [DATA_WIDTH-1:0] s_data_r,
    output logic                  bck,
    output logic                  data_l,
    output logic                  data_r,
    output logic                  le,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(DATA_WIDTH - 1);

    logic [1:0]            state_reg, state_next;
    logic [DIV_W-1:0]      div_reg, div_next;
    logic [BIT_W-1:0]      bit_reg, bit_next;
    logic [DATA_WIDTH-1:0] shift_l_reg, shift_l_next;
    logic [DATA_WIDTH-1:0] shift_r_reg, shift_r_next;
    logic [DATA_WIDTH-1:0] hold_l_reg, hold_r_reg;
    logic                  hold_full_reg, hold_full_next;
    logic                  accept;
    logic                  phase_end;
    logic                  load;

    // s_ready mirrors an empty holding register, so accept and load never coincide
    assign accept    = s_valid && s_ready;
    assign phase_end = (div_reg == DIV_LAST);

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        bit_next       = bit_reg;
        shift_l_next   = shift_l_reg;
        shift_r_next   = shift_r_reg;
        hold_full_next = hold_full_reg;
        load           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hold_full_reg) begin
                    load       = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    div_next   = '0;
                    state_next = HIGH;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    div_next = '0;
                    if (bit_reg != '0) begin
                        shift_l_next = {shift_l_reg[DATA_WIDTH-2:0], 1'b0};
                        shift_r_next = {shift_r_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_next     = bit_reg - 1'b1;
                        state_next   = LOW;
                    end else if (hold_full_reg) begin
                        load       = 1'b1;
                        state_next = LOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            shift_l_next   = hold_l_reg;
            shift_r_next   = hold_r_reg;
            bit_next       = BIT_FIRST;
            div_next       = '0;
            hold_full_next = 1'b0;
        end
        if (accept) begin
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            shift_l_reg   <= '0;
            shift_r_reg   <= '0;
            hold_l_reg    <= '0;
            hold_r_reg    <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_reg       <= bit_next;
            shift_l_reg   <= shift_l_next;
            shift_r_reg   <= shift_r_next;
            hold_full_reg <= hold_full_next;
            if (accept) begin
                hold_l_reg <= s_data_l;
                hold_r_reg <= s_data_r;
            end
        end
    end

    // Pins trail the state by one clk, so data/le move only on the bck falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck     <= 1'b0;
            data_l  <= 1'b0;
            data_r  <= 1'b0;
            le      <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            bck     <= (state_reg == HIGH);
            busy    <= (state_next != IDLE) || hold_full_next;
            s_ready <= !hold_full_next;
            case (state_reg)
                LOW: begin
                    data_l <= shift_l_reg[DATA_WIDTH-1];
                    data_r <= shift_r_reg[DATA_WIDTH-1];
                    le     <= (bit_reg == '0);
                end
                HIGH: begin
                end
                default: le <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/nos_dac_transmitter.md
Name: nos_dac_transmitter

Overview:
Synthesizable serializer that drives the NOS DAC serial interface (bck, data_l, data_r, le) from parallel left/right sample pairs.
- Samples arrive on a valid/ready stream and are shifted out MSB first, both channels in parallel.
- le is asserted for the bit period of each frame's LSB.
- Sits between the sample datapath and the DAC pins; the simulation receiver model in sim/top checks it in the bench.

Parameters:
DATA_WIDTH, 24, bits per channel per frame; legal range 2..32.
CLK_DIV, 2, clk cycles per bck half-period; legal range ≥1. bck period = 2*CLK_DIV clk.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous active-high reset.
s_valid  input  1  sample pair valid.
s_ready  output  1  transmitter can accept a pair; high when the holding register is empty.
s_data_l  input  DATA_WIDTH  left sample.
s_data_r  input  DATA_WIDTH  right sample.
bck  output  1  bit clock to the DAC.
data_l  output  1  left serial data.
data_r  output  1  right serial data.
le  output  1  latch enable; high during the LSB bit period.
busy  output  1  a frame is being shifted or the holding register is full.

Behaviour:
- Reset values: bck=0, data_l=0, data_r=0, le=0, busy=0, s_ready=1. Holding register and shifter are cleared. Reset mid-frame aborts the frame and discards the held sample.
- All outputs are registered; no combinational path from inputs to outputs. s_ready is a registered flag.
- Buffering is two-deep: one holding register plus one shifter.
  - Accept = s_valid && s_ready at a posedge; the pair is written to the holding register.
  - s_ready drops the cycle after an accept and returns high the cycle after the shifter loads from the holding register.
- FSM states:
  - IDLE: bck=0, le=0, data outputs hold their last value. If the holding register is full, load the shifter, set bitcnt=DATA_WIDTH-1 and go to LOW.
  - LOW: bck=0 for CLK_DIV clk. data_l/data_r = shifter MSBs; le = (bitcnt==0). Then go to HIGH.
  - HIGH: bck=1 for CLK_DIV clk; data and le stay stable. At the end of HIGH, bck returns to 0 and:
    - bitcnt≠0: shift both shifters left by 1, decrement bitcnt, go to LOW.
    - bitcnt==0, holding register full: load the shifter in the same cycle, bitcnt=DATA_WIDTH-1, go to LOW. No gap between frames.
    - bitcnt==0, holding register empty: clear le and go to IDLE.
- Setup/hold: data and le change only on the clk edge where bck falls, or while bck is low. They are stable for CLK_DIV clk before each bck rise and through the whole high phase.
- Latency: an accept at edge N into an idle block gives the MSB on the pins after edge N+2. The first bck rise comes CLK_DIV clk later.
- Frame length: exactly DATA_WIDTH bck rising edges, with le=1 on only the last one. Frame duration = 2*CLK_DIV*DATA_WIDTH clk.
- Receiver view: the captured 32-bit word = sample zero-extended, i.e. {(32-DATA_WIDTH) zeros, sample}.
- Underrun: when the holding register is empty at frame end, bck stays low and le stays low. No extra edges and no repeated sample.
- An accept in the same cycle the shifter loads from the holding register is not possible, because s_ready is registered low in that cycle. The accept takes effect one cycle later.
- busy = (state≠IDLE) || holding register full.

Test Plan:
1. Single pair (DATA_WIDTH=24, CLK_DIV=2): L=0x123456, R=0xABCDEF -> receiver Data_l[0]=0x00123456, Data_r[0]=0x00ABCDEF. 24 bck rises with period 4 clk; le high only on the 24th rise; bck idle low afterwards; busy returns to 0.
2. Back-to-back: 8 pairs with s_valid held high (L=i, R=~i masked to 24 bits) -> 8 pairs received in order. 192 continuous bck rises with no gap; le on rises 24, 48, …, 192.
3. Backpressure: s_valid held high from idle -> pair0 accepted, s_ready low, pair1 accepted one cycle after the shifter loads pair0. Pair2 waits until pair0's frame ends; no pair lost or duplicated.
4. Reset mid-frame: assert rst after 10 bck rises -> all outputs 0 asynchronously, receiver collects no word. After release, pair 0x0000AA/0x000055 is received correctly as the first word.
5. Extremes: DATA_WIDTH=32, CLK_DIV=1, L=0xFFFFFFFF/R=0x80000000, then L=0x00000000/R=0x00000001 -> received exactly; bck period 2 clk; setup ≥1 clk before each rise.
6. Underrun gap: two pairs separated by 100 idle clk -> no bck edges and le=0 during the gap; exactly 2 words received.
